qsram: RTL and testbench

Dual-banked Q-vector staging buffer that sits between the memory controller and the PE array on the load path. The memory controller streams Q vectors in one per cycle. The PE array then consumes a whole bank at once, with every row presented in parallel, one row per PE. Two banks ping-pong so that one bank can fill while the other is held stable for the PEs. A `load_last` marker closes a partially filled bank for tail tiles.

---
 rtl/qsram.sv | 96 +++++++++
 tb/tb_qsram.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/qsram.sv
// Dual-banked Q-vector staging buffer: rows stream in one per cycle from the memory
// controller, and a full bank is presented in parallel to the PE array (ping-pong).
`ifndef NUM_PES
`define NUM_PES 4
`endif

module qsram #(
   parameter int unsigned NUM_ROWS   = `NUM_PES,
   parameter type         Q_VECTOR_T = logic [31:0]
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          load_valid,
   input  logic                          load_last,
   input  Q_VECTOR_T                     load_data,
   output logic                          load_ready,
   input  logic                          read_enable,
   output logic                          read_data_valid,
   output Q_VECTOR_T                     read_data [NUM_ROWS],
   output logic [NUM_ROWS-1:0]           read_row_valid,
   output logic [$clog2(NUM_ROWS+1)-1:0] read_rows
);

   localparam int unsigned IDX_W = $clog2(NUM_ROWS);
   localparam int unsigned CNT_W = $clog2(NUM_ROWS + 1);

   typedef enum logic [1:0] {
      BANK_EMPTY   = 2'd0,
      BANK_FILLING = 2'd1,
      BANK_FULL    = 2'd2
   } bank_state_t;

   bank_state_t          state [2];
   logic [NUM_ROWS-1:0]  mask [2];
   logic                 fill_bank;
   logic                 read_bank;
   logic [IDX_W-1:0]     load_idx;
   Q_VECTOR_T            mem [2][NUM_ROWS];

   logic load_accept;
   logic bank_close;
   logic consume;

   assign load_ready      = (state[fill_bank] != BANK_FULL);
   assign read_data_valid = (state[read_bank] == BANK_FULL);
   assign load_accept     = load_valid && load_ready;
   assign bank_close      = load_accept && ((load_idx == IDX_W'(NUM_ROWS - 1)) || load_last);
   assign consume         = read_enable && read_data_valid;

   // Bank states, pointers and masks; a consume and a close always target different banks.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int b = 0; b < 2; b++) begin
            state[b] <= BANK_EMPTY;
            mask[b]  <= '0;
         end
         fill_bank <= 1'b0;
         read_bank <= 1'b0;
         load_idx  <= '0;
      end else begin
         if (consume) begin
            state[read_bank] <= BANK_EMPTY;
            mask[read_bank]  <= '0;
            read_bank        <= ~read_bank;
         end
         if (load_accept) begin
            mask[fill_bank][load_idx] <= 1'b1;
            if (bank_close) begin
               state[fill_bank] <= BANK_FULL;
               fill_bank        <= ~fill_bank;
               load_idx         <= '0;
            end else begin
               state[fill_bank] <= BANK_FILLING;
               load_idx         <= load_idx + IDX_W'(1);
            end
         end
      end
   end

   // Row storage carries no reset; the masks gate everything that reaches the outputs.
   always_ff @(posedge clk) begin
      if (load_accept) begin
         mem[fill_bank][load_idx] <= load_data;
      end
   end

   always_comb begin
      read_row_valid = read_data_valid ? mask[read_bank] : '0;
      read_rows      = '0;
      for (int i = 0; i < NUM_ROWS; i++) begin
         read_data[i] = read_row_valid[i] ? mem[read_bank][i] : '0;
         read_rows    = read_rows + CNT_W'(read_row_valid[i]);
      end
   end

endmodule

// File: tb/tb_qsram.sv
// Directed bench for qsram: loaded rows go to a scoreboard and are compared when their bank is presented.
`timescale 1ns/1ps

module tb_qsram;

   localparam int unsigned NR = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        load_valid;
   logic        load_last;
   logic [31:0] load_data;
   logic        load_ready;
   logic        read_enable;
   logic        read_data_valid;
   logic [31:0] read_data [NR];
   logic [NR-1:0] read_row_valid;
   logic [2:0]  read_rows;

   int checks = 0;
   int errors = 0;

   logic [31:0] row_q [$];
   int          cnt_q [$];
   int          cur_cnt = 0;

   qsram #(.NUM_ROWS(NR), .Q_VECTOR_T(logic [31:0])) dut (
      .clk             (clk),
      .rst             (rst),
      .load_valid      (load_valid),
      .load_last       (load_last),
      .load_data       (load_data),
      .load_ready      (load_ready),
      .read_enable     (read_enable),
      .read_data_valid (read_data_valid),
      .read_data       (read_data),
      .read_row_valid  (read_row_valid),
      .read_rows       (read_rows)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One accepted load; the bench tracks its own fill count to know where banks close.
   task automatic load(input logic [31:0] d, input logic last, input logic rd);
      chk("load_ready_pre", 32'(load_ready), 32'd1);
      load_valid  = 1'b1;
      load_data   = d;
      load_last   = last;
      read_enable = rd;
      step();
      load_valid  = 1'b0;
      load_last   = 1'b0;
      read_enable = 1'b0;
      row_q.push_back(d);
      cur_cnt++;
      if (last || cur_cnt == NR) begin
         cnt_q.push_back(cur_cnt);
         cur_cnt = 0;
      end
   endtask

   task automatic consume();
      read_enable = 1'b1;
      step();
      read_enable = 1'b0;
   endtask

   task automatic check_bank(input string tag);
      int n;
      logic [31:0] e;
      logic [NR-1:0] m;
      chk({tag, "_valid"}, 32'(read_data_valid), 32'd1);
      checks++;
      assert (cnt_q.size() != 0) else begin
         errors++;
         $error("FAIL %s_sb observed=empty expected=bank", tag);
      end
      if (cnt_q.size() != 0) begin
         n = cnt_q.pop_front();
         m = NR'((1 << n) - 1);
         chk({tag, "_rows"}, 32'(read_rows), 32'(n));
         chk({tag, "_mask"}, 32'(read_row_valid), 32'(m));
         for (int i = 0; i < NR; i++) begin
            e = (i < n && row_q.size() != 0) ? row_q.pop_front() : 32'd0;
            chk($sformatf("%s_row%0d", tag, i), read_data[i], e);
         end
      end
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "_ready"}, 32'(load_ready), 32'd1);
      chk({tag, "_valid"}, 32'(read_data_valid), 32'd0);
      chk({tag, "_mask"}, 32'(read_row_valid), 32'd0);
      chk({tag, "_rows"}, 32'(read_rows), 32'd0);
      for (int i = 0; i < NR; i++) chk($sformatf("%s_data%0d", tag, i), read_data[i], 32'd0);
   endtask

   initial begin
      rst = 1'b1; load_valid = 1'b0; load_last = 1'b0; load_data = '0; read_enable = 1'b0;
      step();
      step();
      rst = 1'b0;
      check_idle("reset");

      // Spurious controls: no valid bank to consume, load_last without load_valid
      read_enable = 1'b1; load_last = 1'b1; load_data = 32'hDEAD_0000;
      step();
      read_enable = 1'b0; load_last = 1'b0;
      check_idle("spurious");
      chk("spurious_idx", 32'(dut.load_idx), 32'd0);

      // Full bank handoff, then a partial bank behind it
      for (int i = 0; i < 4; i++) load(32'hA000_0000 + 32'(i), 1'b0, 1'b0);
      check_bank("full_a");
      load(32'hB000_0000, 1'b0, 1'b0);
      load(32'hB000_0001, 1'b1, 1'b0);
      chk("a_still_shown", read_data[3], 32'hA000_0003);
      consume();
      check_bank("partial_b");
      consume();
      chk("drained_valid", 32'(read_data_valid), 32'd0);
      chk("drained_rows", 32'(read_rows), 32'd0);

      // Both banks full: held load stalls until a consume frees a bank
      for (int i = 0; i < 8; i++) begin
         load(32'hD000_0000 + 32'(i), 1'b0, 1'b0);
         if (i == 3) check_bank("both_d0");
      end
      chk("both_ready", 32'(load_ready), 32'd0);
      load_valid = 1'b1; load_data = 32'hBAD0_BAD0;
      step();
      step();
      chk("held_ready", 32'(load_ready), 32'd0);
      chk("held_valid", 32'(read_data_valid), 32'd1);
      chk("held_row0", read_data[0], 32'hD000_0000);
      read_enable = 1'b1;
      step();
      read_enable = 1'b0; load_valid = 1'b0;
      check_bank("both_d1");
      chk("after_consume_ready", 32'(load_ready), 32'd1);

      // Simultaneous close of bank1 and consume of bank0
      for (int i = 0; i < 4; i++) load(32'hE000_0000 + 32'(i), 1'b0, 1'b0);
      chk("e_wait_ready", 32'(load_ready), 32'd0);
      consume();
      check_bank("e_bank");
      for (int i = 0; i < 3; i++) load(32'hF000_0000 + 32'(i), 1'b0, 1'b0);
      load(32'hF000_0003, 1'b0, 1'b1);
      check_bank("simul_f");
      chk("simul_ready", 32'(load_ready), 32'd1);
      consume();

      // Reset with bank0 FULL and bank1 partly filled
      for (int i = 0; i < 4; i++) load(32'h6000_0000 + 32'(i), 1'b0, 1'b0);
      check_bank("g_bank");
      load(32'h7000_0000, 1'b0, 1'b0);
      load(32'h7000_0001, 1'b0, 1'b0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      row_q.delete(); cnt_q.delete(); cur_cnt = 0;
      check_idle("midreset");
      load(32'h1234_5678, 1'b1, 1'b0);
      check_bank("single_row");
      chk("single_idx", 32'(dut.load_idx), 32'd0);
      chk("sb_drained", 32'(row_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
